// File: rtl/ocp_block_copier_pkg.sv
// Shared OCP constants, bus widths and address helpers for the block copier.
package ocp_block_copier_pkg;

   // Bus widths
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BEN_WIDTH  = DATA_WIDTH / 8;

   // OCP MCmd encodings
   localparam logic [2:0] OCP_CMD_IDLE = 3'b000;
   localparam logic [2:0] OCP_CMD_WR   = 3'b001;
   localparam logic [2:0] OCP_CMD_RD   = 3'b010;

   // OCP SResp encodings
   localparam logic [1:0] OCP_RESP_DVA = 2'b01;
   localparam logic [1:0] OCP_RESP_ERR = 2'b11;

   // Byte distance between consecutive 32-bit words
   localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

   // Force a byte address onto a 32-bit word boundary
   function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
      return addr & ~ADDR_WIDTH'(3);
   endfunction

endpackage

// File: rtl/ocp_block_copier.sv
// OCP initiator that copies a block of 32-bit words from src to dst, one
// read followed by one write per word, aborting on an error response.
module ocp_block_copier
   import ocp_block_copier_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_src,
   input  logic [ADDR_WIDTH-1:0] i_dst,
   input  logic [CNT_WIDTH-1:0]  i_count,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [CNT_WIDTH-1:0]  o_words,
   output logic [ADDR_WIDTH-1:0] o_MAddr,
   output logic [2:0]            o_MCmd,
   output logic [DATA_WIDTH-1:0] o_MData,
   output logic [BEN_WIDTH-1:0]  o_MByteEn,
   input  logic                  i_SCmdAccept,
   input  logic [DATA_WIDTH-1:0] i_SData,
   input  logic [1:0]            i_SResp
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_CMD  = 2'd1,
      S_RD_WAIT = 2'd2,
      S_WR_CMD  = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr, src_nxt, dst_nxt;
   logic [DATA_WIDTH-1:0] data_buf, buf_nxt;
   logic [CNT_WIDTH-1:0]  remaining;
   logic                  start_copy, start_empty, rd_ok, wr_ok, wr_last, abort;

   // Next-state decode plus next pointer/buffer values; outputs are registered
   // from these so every OCP signal leaves a flop.
   always_comb begin
      state_nxt   = state;
      start_copy  = 1'b0;
      start_empty = 1'b0;
      rd_ok       = 1'b0;
      wr_ok       = 1'b0;
      abort       = 1'b0;
      wr_last     = (remaining == CNT_WIDTH'(1));
      case (state)
         S_IDLE: begin
            if (i_start) begin
               if (i_count == '0) begin
                  start_empty = 1'b1;
               end else begin
                  start_copy = 1'b1;
                  state_nxt  = S_RD_CMD;
               end
            end
         end
         S_RD_CMD: begin
            // A response is only meaningful once the read has been accepted
            if (i_SCmdAccept) begin
               if (i_SResp == OCP_RESP_DVA) begin
                  rd_ok     = 1'b1;
                  state_nxt = S_WR_CMD;
               end else if (i_SResp == OCP_RESP_ERR) begin
                  abort     = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (i_SResp == OCP_RESP_DVA) begin
               rd_ok     = 1'b1;
               state_nxt = S_WR_CMD;
            end else if (i_SResp == OCP_RESP_ERR) begin
               abort     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WR_CMD: begin
            if (i_SCmdAccept) begin
               wr_ok     = 1'b1;
               state_nxt = wr_last ? S_IDLE : S_RD_CMD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      src_nxt = src_ptr;
      dst_nxt = dst_ptr;
      buf_nxt = data_buf;
      if (start_copy || start_empty) begin
         src_nxt = word_align(i_src);
         dst_nxt = word_align(i_dst);
      end
      // Pointers wrap naturally at the address width
      if (wr_ok) begin
         src_nxt = src_ptr + WORD_BYTES;
         dst_nxt = dst_ptr + WORD_BYTES;
      end
      if (rd_ok) begin
         buf_nxt = i_SData;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Address pointers and read data buffer; only consumed after a start loads them
   always_ff @(posedge clk) begin
      src_ptr  <= src_nxt;
      dst_ptr  <= dst_nxt;
      data_buf <= buf_nxt;
   end

   // Registered status, progress counter and OCP request outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_error   <= 1'b0;
         o_words   <= '0;
         o_MCmd    <= OCP_CMD_IDLE;
         o_MAddr   <= '0;
         o_MData   <= '0;
         o_MByteEn <= '0;
      end else begin
         o_busy <= (state_nxt != S_IDLE);
         o_done <= start_empty | abort | (wr_ok & wr_last);
         if (start_copy || start_empty) begin
            remaining <= i_count;
            o_words   <= '0;
            o_error   <= 1'b0;
         end
         if (wr_ok) begin
            remaining <= remaining - CNT_WIDTH'(1);
            o_words   <= o_words + CNT_WIDTH'(1);
         end
         if (abort) begin
            o_error <= 1'b1;
         end
         case (state_nxt)
            S_RD_CMD: begin
               o_MCmd    <= OCP_CMD_RD;
               o_MAddr   <= src_nxt;
               o_MByteEn <= '1;
            end
            S_WR_CMD: begin
               o_MCmd    <= OCP_CMD_WR;
               o_MAddr   <= dst_nxt;
               o_MData   <= buf_nxt;
               o_MByteEn <= '1;
            end
            default: begin
               o_MCmd    <= OCP_CMD_IDLE;
               o_MByteEn <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ocp_block_copier.sv
// Bench for ocp_block_copier: OCP slave memory model with random stalls,
// latencies and error injection, compared against a word-copy reference.
module tb_ocp_block_copier;

   localparam logic [2:0] C_IDLE = 3'b000;
   localparam logic [2:0] C_WR   = 3'b001;
   localparam logic [2:0] C_RD   = 3'b010;
   localparam logic [1:0] R_NULL = 2'b00;
   localparam logic [1:0] R_DVA  = 2'b01;
   localparam logic [1:0] R_ERR  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [31:0] i_src, i_dst;
   logic [15:0] i_count;
   logic        o_busy, o_done, o_error;
   logic [15:0] o_words;
   logic [31:0] o_MAddr, o_MData;
   logic [2:0]  o_MCmd;
   logic [3:0]  o_MByteEn;
   logic        i_SCmdAccept;
   logic [31:0] i_SData;
   logic [1:0]  i_SResp;

   int total = 0;
   int bad   = 0;

   ocp_block_copier #(.CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_src(i_src), .i_dst(i_dst),
      .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_words(o_words), .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData),
      .o_MByteEn(o_MByteEn), .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData),
      .i_SResp(i_SResp)
   );

   always #5 clk = ~clk;

   // ---------------- memory ----------------
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] fill(input logic [31:0] a);
      return a ^ 32'hC0DE_5A5A;
   endfunction
   function automatic logic [31:0] peek_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : fill(a);
   endfunction
   function automatic logic [31:0] peek_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // ---------------- slave model ----------------
   int  stall_max = 0, lat_min = 1, lat_max = 1, wait_left = 0, err_idx = -1;
   int  n_reads = 0, n_writes = 0, pend = -1, lat;
   bit  block_wr = 0, noise = 0, prev_pend = 0, rst_at_edge = 1, drove;
   bit  pend_err;
   logic [31:0] pend_data, p_addr, p_data;
   logic [2:0]  p_cmd;
   logic [3:0]  p_ben;
   logic [31:0] rd_q[$], wr_q[$];

   always @(posedge clk) rst_at_edge = rst;

   always @(negedge clk) begin
      i_SResp      = R_NULL;
      i_SData      = $urandom;
      i_SCmdAccept = 1'b0;
      drove        = 0;
      if (pend == 1) begin
         i_SResp = pend_err ? R_ERR : R_DVA;
         i_SData = pend_data;
         pend    = -1;
         drove   = 1;
      end else if (pend > 1) begin
         pend--;
      end
      if (!drove && pend == -1 && noise) i_SResp = 2'($urandom);
      if (prev_pend && !rst_at_edge) begin
         total++;
         if ({o_MCmd, o_MAddr, o_MData, o_MByteEn} !== {p_cmd, p_addr, p_data, p_ben}) begin
            bad++;
            $display("FAIL cmd_hold: got cmd=%0d addr=%h data=%h ben=%h, required cmd=%0d addr=%h data=%h ben=%h",
                     o_MCmd, o_MAddr, o_MData, o_MByteEn, p_cmd, p_addr, p_data, p_ben);
         end
      end
      prev_pend = 0;
      if (o_MCmd == C_RD || o_MCmd == C_WR) begin
         if (wait_left > 0 || (block_wr && o_MCmd == C_WR)) begin
            if (wait_left > 0) wait_left--;
            prev_pend = 1;
            p_cmd = o_MCmd; p_addr = o_MAddr; p_data = o_MData; p_ben = o_MByteEn;
         end else begin
            i_SCmdAccept = 1'b1;
            wait_left = $urandom_range(0, stall_max);
            total++;
            if (o_MByteEn !== 4'hF) begin
               bad++;
               $display("FAIL byte_enable: got %h required f", o_MByteEn);
            end
            if (o_MCmd == C_WR) begin
               mem[o_MAddr] = o_MData;
               wr_q.push_back(o_MAddr);
               n_writes++;
            end else begin
               rd_q.push_back(o_MAddr);
               pend_err  = (n_reads == err_idx);
               pend_data = peek_mem(o_MAddr);
               n_reads++;
               lat = $urandom_range(lat_min, lat_max);
               if (lat == 0) begin
                  i_SResp = pend_err ? R_ERR : R_DVA;
                  i_SData = pend_data;
               end else begin
                  i_SResp = R_NULL;
                  pend = lat;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int done_cnt = 0, busy_cnt = 0, cmd_cnt = 0;
   always @(negedge clk) begin
      if (o_done === 1'b1) done_cnt++;
      if (o_busy === 1'b1) busy_cnt++;
      if (o_MCmd !== C_IDLE) cmd_cnt++;
   end

   task automatic clear_counts();
      @(posedge clk);
      done_cnt = 0; busy_cnt = 0; cmd_cnt = 0; n_reads = 0; n_writes = 0;
      rd_q.delete(); wr_q.delete();
   endtask

   // One copy from request to settled status, checked against the word-copy reference
   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input bit poke, output int done_at);
      logic [31:0] a, d;
      logic [31:0] exp_rd[$], exp_wr[$];
      int  words;
      bit  err, ok;
      ref_mem = mem;
      clear_counts();
      @(negedge clk);
      i_start = 1'b1; i_src = src; i_dst = dst; i_count = 16'(cnt);
      done_at = -1;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         i_start = 1'b0; i_src = $urandom; i_dst = $urandom; i_count = 16'($urandom);
         if (poke && o_busy && $urandom_range(0, 3) == 0) i_start = 1'b1;
         if (o_done) begin done_at = c; break; end
      end
      i_start = 1'b0;
      total++;
      if (done_at < 0) begin bad++; $display("FAIL copy_timeout: no o_done within 1000 cycles"); end
      repeat (3) @(negedge clk);
      @(posedge clk);

      a = src & ~32'h3; d = dst & ~32'h3; words = 0; err = 0;
      for (int i = 0; i < cnt; i++) begin
         exp_rd.push_back(a);
         if (i == err_idx) begin err = 1; break; end
         ref_mem[d] = peek_ref(a);
         exp_wr.push_back(d);
         a += 32'd4; d += 32'd4; words++;
      end

      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL done_count: got %0d required 1", done_cnt); end
      total++;
      if (o_error !== err) begin bad++; $display("FAIL error_flag: got %b required %b", o_error, err); end
      total++;
      if (o_words !== 16'(words)) begin bad++; $display("FAIL words: got %0d required %0d", o_words, words); end
      total++;
      if (o_busy !== 1'b0 || o_MCmd !== C_IDLE) begin
         bad++; $display("FAIL idle_after: got busy=%b cmd=%0d required busy=0 cmd=0", o_busy, o_MCmd);
      end
      ok = (rd_q.size() == exp_rd.size());
      for (int i = 0; ok && i < exp_rd.size(); i++) if (rd_q[i] !== exp_rd[i]) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL read_addrs: got %0d reads required %0d from %h", rd_q.size(), exp_rd.size(), src & ~32'h3); end
      ok = (wr_q.size() == exp_wr.size());
      for (int i = 0; ok && i < exp_wr.size(); i++) if (wr_q[i] !== exp_wr[i]) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL write_addrs: got %0d writes required %0d to %h", wr_q.size(), exp_wr.size(), dst & ~32'h3); end
      foreach (exp_wr[i]) begin
         total++;
         if (peek_mem(exp_wr[i]) !== peek_ref(exp_wr[i])) begin
            bad++;
            $display("FAIL mem_word: at %h got %h required %h", exp_wr[i], peek_mem(exp_wr[i]), peek_ref(exp_wr[i]));
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_src = '0; i_dst = '0; i_count = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (o_MCmd !== C_IDLE) begin bad++; $display("FAIL rst_cmd: got %0d required 0", o_MCmd); end
      total++; if (o_MAddr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h required 0", o_MAddr); end
      total++; if (o_MData !== 32'h0) begin bad++; $display("FAIL rst_data: got %h required 0", o_MData); end
      total++; if (o_MByteEn !== 4'h0) begin bad++; $display("FAIL rst_ben: got %h required 0", o_MByteEn); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", o_done); end
      total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b required 0", o_error); end
      total++; if (o_words !== 16'h0) begin bad++; $display("FAIL rst_words: got %0d required 0", o_words); end
   endtask

   task automatic test_basic();
      int t;
      mem[32'h0] = 32'hdeadbeef;
      mem[32'h4] = 32'h12345678;
      run_copy(32'h0, 32'h100, 2, 0, t);
      total++; if (peek_mem(32'h100) !== 32'hdeadbeef) begin bad++; $display("FAIL basic_w0: got %h required deadbeef", peek_mem(32'h100)); end
      total++; if (peek_mem(32'h104) !== 32'h12345678) begin bad++; $display("FAIL basic_w1: got %h required 12345678", peek_mem(32'h104)); end
      total++; if (busy_cnt != 6) begin bad++; $display("FAIL basic_busy: got %0d cycles required 6", busy_cnt); end
      total++; if (t != 7) begin bad++; $display("FAIL basic_latency: got %0d required 7", t); end
   endtask

   task automatic test_zero_count();
      int t;
      run_copy(32'h40, 32'h80, 0, 0, t);
      total++; if (t != 1) begin bad++; $display("FAIL zero_latency: got %0d required 1", t); end
      total++; if (cmd_cnt != 0 || busy_cnt != 0) begin bad++; $display("FAIL zero_idle: got cmd cycles %0d busy cycles %0d required 0", cmd_cnt, busy_cnt); end
   endtask

   task automatic test_stall();
      int t;
      wait_left = 5;
      run_copy(32'h800, 32'h900, 3, 0, t);
      total++; if (t != 15) begin bad++; $display("FAIL stall_latency: got %0d required 15", t); end
   endtask

   task automatic test_error();
      int t;
      err_idx = 0;
      run_copy(32'hA00, 32'hB00, 4, 0, t);
      err_idx = -1;
      repeat (5) @(negedge clk);
      total++; if (o_error !== 1'b1) begin bad++; $display("FAIL error_hold: got %b required 1", o_error); end
      run_copy(32'hA00, 32'hB00, 1, 0, t);
   endtask

   task automatic test_wrap();
      int t;
      run_copy(32'hFFFF_FFFC, 32'h200, 2, 0, t);
      total++;
      if (rd_q.size() != 2 || rd_q[rd_q.size()-1] !== 32'h0) begin
         bad++; $display("FAIL wrap_addr: got %0d reads, last %h required second read at 00000000", rd_q.size(), rd_q[rd_q.size()-1]);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      bit seen;
      block_wr = 1;
      clear_counts();
      @(negedge clk);
      i_start = 1'b1; i_src = 32'h300; i_dst = 32'h400; i_count = 16'd3;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_MCmd === C_WR) begin seen = 1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL mid_reach_write: got no write command required one"); end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (o_MCmd !== C_IDLE || o_busy !== 1'b0 || o_done !== 1'b0) begin
         bad++; $display("FAIL mid_reset: got cmd=%0d busy=%b done=%b required 0/0/0", o_MCmd, o_busy, o_done);
      end
      rst = 1'b0;
      block_wr = 0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      total++; if (done_cnt != 0 || n_writes != 0) begin bad++; $display("FAIL mid_no_done: got done=%0d writes=%0d required 0/0", done_cnt, n_writes); end

      // reset while a read response is still outstanding
      lat_min = 4; lat_max = 4;
      clear_counts();
      @(negedge clk);
      i_start = 1'b1; i_src = 32'h500; i_dst = 32'h600; i_count = 16'd2;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_MCmd === C_RD) begin seen = 1; break; end
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      done_cnt = 0; busy_cnt = 0; cmd_cnt = 0;
      repeat (8) @(negedge clk);
      @(posedge clk);
      total++;
      if (!seen || cmd_cnt != 0 || done_cnt != 0 || busy_cnt != 0) begin
         bad++; $display("FAIL late_resp: got read=%b cmd=%0d done=%0d busy=%0d required 1/0/0/0", seen, cmd_cnt, done_cnt, busy_cnt);
      end
      lat_min = 1; lat_max = 1;
      run_copy(32'h300, 32'h400, 3, 0, t);
   endtask

   task automatic test_random();
      int t, cnt;
      noise = 1;
      for (int k = 0; k < 25; k++) begin
         stall_max = $urandom_range(0, 3);
         lat_min   = $urandom_range(0, 1);
         lat_max   = $urandom_range(lat_min, 3);
         cnt       = $urandom_range(0, 6);
         if (cnt > 0 && $urandom_range(0, 4) == 0) begin
            err_idx = $urandom_range(0, cnt - 1);
            lat_min = 1;
            if (lat_max < 1) lat_max = 1;
         end
         run_copy($urandom, $urandom, cnt, 1, t);
         err_idx = -1;
      end
      noise = 0; stall_max = 0; lat_min = 1; lat_max = 1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_stall();
      test_error();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ocp_block_copier.md
OCP_BLOCK_COPIER -- requirements
Module: ocp_block_copier

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the word-count input and the progress counter.
REQ-003 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  synchronous active-high reset.
REQ-005 SHALL have i_start  input  1  single-cycle copy request, sampled only in IDLE.
REQ-006 SHALL have i_src  input  ADDR_WIDTH  source byte address.
REQ-007 SHALL have i_dst  input  ADDR_WIDTH  destination byte address.
REQ-008 SHALL have i_count  input  CNT_WIDTH  number of 32-bit words to copy.
REQ-009 SHALL have o_busy  output  1  copy in progress.
REQ-010 SHALL have o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have o_error  output  1  last copy aborted on an error response.
REQ-012 SHALL have o_words  output  CNT_WIDTH  words fully written in current/last copy.
REQ-013 SHALL have OCP initiator ports: o_MAddr (ADDR_WIDTH), o_MCmd (3), o_MData (DATA_WIDTH), o_MByteEn (BEN_WIDTH) as outputs; i_SCmdAccept (1), i_SData (DATA_WIDTH), i_SResp (2) as inputs.

Function
REQ-014 SHALL implement states IDLE, RD_CMD, RD_WAIT, WR_CMD; all outputs registered.
REQ-015 IDLE: o_MCmd=OCP_CMD_IDLE, o_busy=0; on i_start latch src/dst with bits [1:0] forced to 0, latch count, clear o_words and o_error.
REQ-016 i_start with i_count=0 SHALL pulse o_done the next cycle, stay IDLE, and issue no OCP command.
REQ-017 i_start with i_count>0 SHALL enter RD_CMD and set o_busy=1 the next cycle.
REQ-018 RD_CMD: drive o_MCmd=READ, o_MAddr=src pointer, o_MByteEn=all ones; hold all stable until a cycle with i_SCmdAccept=1, then enter RD_WAIT.
REQ-019 If i_SResp=DVA in the same cycle as accept in RD_CMD, SHALL capture i_SData and go directly to WR_CMD.
REQ-020 RD_WAIT: o_MCmd=IDLE; on i_SResp=DVA capture i_SData into the data buffer and enter WR_CMD; on i_SResp=ERR abort.
REQ-021 WR_CMD: drive o_MCmd=WRITE, o_MAddr=dst pointer, o_MData=buffer, o_MByteEn=all ones; hold until i_SCmdAccept=1.
REQ-022 On write accept: src+=4, dst+=4, o_words+=1, remaining-=1; if remaining reaches 0, pulse o_done, clear o_busy, go IDLE; else go RD_CMD.
REQ-023 Pointer arithmetic SHALL be modulo 2^ADDR_WIDTH (0xFFFFFFFC+4 wraps to 0).
REQ-024 Abort SHALL pulse o_done with o_error=1, clear o_busy, return to IDLE; o_error SHALL hold until the next accepted i_start.
REQ-025 i_SResp SHALL be ignored in IDLE, WR_CMD, and in RD_CMD before accept; i_start SHALL be ignored while o_busy=1.
REQ-026 With a slave that accepts immediately and responds one cycle later, throughput SHALL be 3 cycles per word.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, o_MCmd=IDLE, o_MAddr=0, o_MData=0, o_MByteEn=0, o_busy=0, o_done=0, o_error=0, o_words=0, regardless of state.
REQ-028 Reset mid-copy SHALL abandon the transfer without an o_done pulse; responses arriving afterwards SHALL be ignored.

Structure
REQ-029 OCP command/response codes SHALL come from the shared ocp_const.vh; ADDR/DATA/BEN widths from common.vh; state encodings local.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 src=0x0, dst=0x100, count=2, memory preloaded 0xdeadbeef, 0x12345678 -> words at 0x100/0x104 match, o_words=2, one o_done, o_error=0, 6 busy cycles.
REQ-032 count=0 -> o_done one cycle after start, o_MCmd stays IDLE throughout.
REQ-033 i_SCmdAccept held low 5 cycles during RD_CMD -> o_MCmd/o_MAddr remain stable for all 5 cycles; copy completes correctly.
REQ-034 i_SResp=ERR on first read of count=4 -> o_done with o_error=1, o_words=0, no write issued.
REQ-035 src=0xFFFFFFFC, count=2 -> second read address 0x00000000.
REQ-036 rst asserted in WR_CMD of word 1 of 3 -> next cycle o_MCmd=IDLE, o_busy=0, no o_done; a new start then copies correctly.
